tick_gen: RTL and testbench

Multi-channel programmable tick generator. It replaces the single fixed-divisor enable divider. It produces `NUM_CH` independent one-cycle tick pulses, and each channel has a runtime-programmable period, a continuous or one-shot mode, and a gating enable. A shared sync input restarts all enabled channels phase-aligned. It sits beside the system clock and drives clock-enables for LED blinkers, debouncers, UART baud and sampling logic.

---
 rtl/tick_gen_pkg.sv | 25 ++
 rtl/tick_gen_ch.sv | 139 +++++++++++++
 rtl/tick_gen.sv | 68 ++++++
 tb/tb_tick_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared types and helpers for the multi-channel tick generator.
//   tick_mode_e  - continuous / one-shot channel behaviour
//   tick_state_e - per-channel run state
//   eff_div()    - divisor clamp: a divisor of 0 behaves like 1
package tick_gen_pkg;

  typedef enum logic {
    TM_CONT    = 1'b0,
    TM_ONESHOT = 1'b1
  } tick_mode_e;

  typedef enum logic {
    TS_IDLE = 1'b0,
    TS_RUN  = 1'b1
  } tick_state_e;

  // Widest counter the helper supports; channels zero-extend into it.
  localparam int unsigned MAX_CNT_W = 64;

  // Effective period in clk cycles: max(div, 1).
  function automatic logic [MAX_CNT_W-1:0] eff_div(input logic [MAX_CNT_W-1:0] div);
    return (div == '0) ? MAX_CNT_W'(1) : div;
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one tick channel (down-counter, IDLE/RUN FSM, pending config shadow).
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   cfg_we_i        - accepted config write targeting this channel
//   cfg_div_i       - new period in clk cycles
//   cfg_mode_i      - 0 continuous, 1 one-shot
//   ch_en_i         - run enable (level)
//   sync_i          - restart (phase-align) if enabled
//   tick_o          - registered one-cycle tick
//   busy_o          - channel is in RUN
//   pend_o          - a config write is parked in the shadow
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic             cfg_mode_i,
  input  logic             ch_en_i,
  input  logic             sync_i,
  output logic             tick_o,
  output logic             busy_o,
  output logic             pend_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  tick_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  tick_mode_e       mode_q, mode_d;
  logic             pend_v_q, pend_v_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  tick_mode_e       pend_mode_q, pend_mode_d;
  logic             en_q;
  logic             tick_q, tick_d;

  // Divisor/mode in force this edge, after any pending apply.
  logic [CNT_W-1:0] cur_div;
  tick_mode_e       cur_mode;
  logic             apply, load;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    mode_d      = mode_q;
    pend_v_d    = pend_v_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    tick_d      = 1'b0;
    apply       = 1'b0;
    load        = 1'b0;

    // Priority: enable low, sync, rising-edge start, terminal count.
    if (!ch_en_i) begin
      state_d = TS_IDLE;
      apply   = (state_q == TS_RUN);
    end else if (sync_i) begin
      state_d = TS_RUN;
      apply   = 1'b1;
      load    = 1'b1;
    end else if (!en_q) begin
      state_d = TS_RUN;
      load    = 1'b1;
    end else if (state_q == TS_RUN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        tick_d = 1'b1;
        apply  = 1'b1;
      end
    end

    // Pending shadow is applied before any reload so the reload sees the new divisor.
    cur_div  = (apply && pend_v_q) ? pend_div_q  : div_q;
    cur_mode = (apply && pend_v_q) ? pend_mode_q : mode_q;
    if (apply && pend_v_q) begin
      div_d    = pend_div_q;
      mode_d   = pend_mode_q;
      pend_v_d = 1'b0;
    end

    if (tick_d) begin
      if (cur_mode == TM_CONT) load = 1'b1;
      else                     state_d = TS_IDLE;
    end

    if (load) cnt_d = CNT_W'(eff_div(MAX_CNT_W'(cur_div)) - MAX_CNT_W'(1));

    // A write lands in the shadow only if the channel stays in RUN across this edge;
    // otherwise the channel is (or becomes) idle and takes it directly.
    if (cfg_we_i) begin
      if (state_q == TS_RUN && state_d == TS_RUN) begin
        pend_v_d    = 1'b1;
        pend_div_d  = cfg_div_i;
        pend_mode_d = tick_mode_e'(cfg_mode_i);
      end else begin
        div_d  = cfg_div_i;
        mode_d = tick_mode_e'(cfg_mode_i);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= TS_IDLE;
      cnt_q       <= '0;
      div_q       <= RST_DIV;
      mode_q      <= TM_CONT;
      pend_v_q    <= 1'b0;
      pend_div_q  <= '0;
      pend_mode_q <= TM_CONT;
      en_q        <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      pend_v_q    <= pend_v_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      en_q        <= ch_en_i;
      tick_q      <= tick_d;
    end
  end

  assign tick_o = tick_q;
  assign busy_o = (state_q == TS_RUN);
  assign pend_o = pend_v_q;

endmodule

// File: rtl/tick_gen.sv
// tick_gen: NUM_CH independent programmable tick generators with shared sync.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   cfg_valid   - config write request
//   cfg_ready   - write can be accepted for cfg_ch (0 in reset or while its shadow is full)
//   cfg_ch      - target channel; out-of-range writes are accepted and dropped
//   cfg_div     - period in clk cycles (0 behaves like 1)
//   cfg_mode    - 0 continuous, 1 one-shot
//   ch_en       - per-channel run enable
//   sync_i      - restart all enabled channels phase-aligned
//   tick_o      - per-channel registered tick pulse
//   busy_o      - per-channel RUN indicator
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50000000,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] busy_o
);

  logic [NUM_CH-1:0] pend_v;
  logic [NUM_CH-1:0] cfg_we;

  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pend_v[i];
    end
    if (reset) cfg_ready = 1'b0;

    cfg_we = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_we[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_gen_ch #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cfg_we_i  (cfg_we[g]),
      .cfg_div_i (cfg_div),
      .cfg_mode_i(cfg_mode),
      .ch_en_i   (ch_en[g]),
      .sync_i    (sync_i),
      .tick_o    (tick_o[g]),
      .busy_o    (busy_o[g]),
      .pend_o    (pend_v[g])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: scoreboard bench for tick_gen. The driver advances a behavioural
// model (elapsed-cycles vs period per channel) at each edge and queues the expected
// outputs; a monitor pops and compares them on the falling edge.
module tb_tick_gen;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DEF    = 5;
  localparam int unsigned CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic [NUM_CH-1:0] ch_en;
  logic              sync_i;
  logic [NUM_CH-1:0] tick_o;
  logic [NUM_CH-1:0] busy_o;

  always #5 clk = ~clk;

  tick_gen #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .ch_en    (ch_en),
    .sync_i   (sync_i),
    .tick_o   (tick_o),
    .busy_o   (busy_o)
  );

  typedef struct {
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;
    logic              ready;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_div[NUM_CH], m_pdiv[NUM_CH], m_el[NUM_CH], m_per[NUM_CH];
  bit          m_mode[NUM_CH], m_pmode[NUM_CH], m_pv[NUM_CH];
  bit          m_run[NUM_CH], m_was[NUM_CH], m_en_prev[NUM_CH];
  logic [NUM_CH-1:0] m_tick;

  function automatic int unsigned period_of(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic bit model_ready();
    if (reset) return 1'b0;
    return !m_pv[int'(cfg_ch)];
  endfunction

  function automatic void model_apply(input int c);
    if (m_pv[c]) begin
      m_div[c]  = m_pdiv[c];
      m_mode[c] = m_pmode[c];
      m_pv[c]   = 1'b0;
    end
  endfunction

  // Advance the model across one rising edge using the inputs the DUT sampled.
  function automatic void model_edge();
    bit rdy;
    rdy = model_ready();
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_div[c] = DEF; m_mode[c] = 1'b0; m_pv[c] = 1'b0; m_run[c] = 1'b0;
        m_el[c] = 0; m_per[c] = 1; m_en_prev[c] = 1'b0; m_was[c] = 1'b0;
        m_pdiv[c] = 0; m_pmode[c] = 1'b0;
      end
      m_tick = '0;
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      m_was[c]  = m_run[c];
      m_tick[c] = 1'b0;
      if (!ch_en[c]) begin
        if (m_run[c]) model_apply(c);
        m_run[c] = 1'b0;
      end else if (sync_i || !m_en_prev[c]) begin
        if (sync_i) model_apply(c);
        m_run[c] = 1'b1;
        m_el[c]  = 0;
        m_per[c] = period_of(m_div[c]);
      end else if (m_run[c]) begin
        m_el[c]++;
        if (m_el[c] == m_per[c]) begin
          m_tick[c] = 1'b1;
          model_apply(c);
          if (!m_mode[c]) begin
            m_el[c]  = 0;
            m_per[c] = period_of(m_div[c]);
          end else begin
            m_run[c] = 1'b0;
          end
        end
      end
      m_en_prev[c] = ch_en[c];
    end
    if (cfg_valid && rdy) begin
      int c;
      c = int'(cfg_ch);
      if (m_was[c] && m_run[c]) begin
        m_pv[c] = 1'b1; m_pdiv[c] = cfg_div; m_pmode[c] = cfg_mode;
      end else begin
        m_div[c] = cfg_div; m_mode[c] = cfg_mode;
      end
    end
  endfunction

  // ---------------- driver ----------------
  // Queue this cycle's expectation, then cross one rising edge.
  task automatic step();
    exp_t e;
    for (int c = 0; c < NUM_CH; c++) e.busy[c] = m_run[c];
    e.tick  = m_tick;
    e.ready = model_ready();
    sb_q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg_write(input int ch, input int unsigned div, input bit mode);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = CNT_W'(div);
    cfg_mode  = mode;
    step();
    cfg_valid = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("tick_o", 32'(tick_o), 32'(e.tick));
        check("busy_o", 32'(busy_o), 32'(e.busy));
        check("cfg_ready", 32'(cfg_ready), 32'(e.ready));
      end
    end
  end

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    ch_en = 4'b0001; sync_i = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    // Reset defaults: ch0 enabled through reset, default period 5.
    run(3);
    reset = 1'b0;
    run(16);

    // Divisor clamp on ch1: 0, 1, then 3.
    cfg_write(1, 0, 1'b0);
    ch_en[1] = 1'b1; run(6);
    ch_en[1] = 1'b0; run(1);
    cfg_write(1, 1, 1'b0);
    ch_en[1] = 1'b1; run(5);
    ch_en[1] = 1'b0; run(1);
    cfg_write(1, 3, 1'b0);
    ch_en[1] = 1'b1; run(10);

    // One-shot on ch2, held then re-armed.
    cfg_write(2, 4, 1'b1);
    ch_en[2] = 1'b1; run(10);
    ch_en[2] = 1'b0; run(1);
    ch_en[2] = 1'b1; run(8);

    // Pending config on running ch0: 8 then 2.
    ch_en[0] = 1'b0; run(1);
    cfg_write(0, 8, 1'b0);
    ch_en[0] = 1'b1; run(3);
    cfg_write(0, 2, 1'b0);
    cfg_ch = '0; run(20);

    // Sync of ch0 (6) and ch1 (9) running out of phase.
    ch_en[1:0] = 2'b00; run(1);
    cfg_write(0, 6, 1'b0);
    cfg_write(1, 9, 1'b0);
    ch_en[0] = 1'b1; run(2);
    ch_en[1] = 1'b1; run(4);
    sync_i = 1'b1; run(1);
    sync_i = 1'b0; run(20);
    // Sync landing on a terminal-count edge of ch0 (6 edges after the previous restart).
    sync_i = 1'b1; run(1);
    sync_i = 1'b0; run(5);
    sync_i = 1'b1; run(1);
    sync_i = 1'b0; run(8);

    // Gating mid-period, then reset with a pending write.
    run(3);
    ch_en[0] = 1'b0; run(3);
    ch_en[0] = 1'b1; run(3);
    cfg_write(0, 3, 1'b0);
    reset = 1'b1; run(2);
    reset = 1'b0; run(12);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) ch_en[$urandom_range(NUM_CH-1)] ^= 1'b1;
      sync_i    = ($urandom_range(39) == 0);
      cfg_valid = ($urandom_range(5) == 0);
      cfg_ch    = CH_W'($urandom_range(NUM_CH-1));
      cfg_div   = CNT_W'($urandom_range(12));
      cfg_mode  = ($urandom_range(3) == 0);
      reset     = ($urandom_range(799) == 0);
      step();
    end
    cfg_valid = 1'b0; sync_i = 1'b0; reset = 1'b0;

    @(negedge clk);
    #1;
    done = 1'b1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
